// File: rtl/fetch_mem_arbiter.sv
// Arbitrates the single tagged memory port between icache fetch and dcache traffic,
// tracks tag ownership, routes returns, squashes fetch tags on redirect, and bounds fetch starvation.
module fetch_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              icache_req_i,
  input  logic [XLEN-1:0]   icache_addr_i,
  output logic              icache_accept_o,
  output logic [TAG_W-1:0]  icache_tag_o,
  output logic              icache_data_valid_o,
  output logic [63:0]       icache_data_o,
  output logic [TAG_W-1:0]  icache_resp_tag_o,
  input  logic              fetch_flush_i,
  input  logic              dcache_req_i,
  input  logic [1:0]        dcache_cmd_i,
  input  logic [XLEN-1:0]   dcache_addr_i,
  input  logic [63:0]       dcache_wdata_i,
  output logic              dcache_accept_o,
  output logic [TAG_W-1:0]  dcache_tag_o,
  output logic              dcache_data_valid_o,
  output logic [63:0]       dcache_data_o,
  output logic [TAG_W-1:0]  dcache_resp_tag_o,
  output logic [1:0]        proc2mem_command_o,
  output logic [XLEN-1:0]   proc2mem_addr_o,
  output logic [63:0]       proc2mem_data_o,
  input  logic [TAG_W-1:0]  mem2proc_response_i,
  input  logic [63:0]       mem2proc_data_i,
  input  logic [TAG_W-1:0]  mem2proc_tag_i,
  output logic              inst_priority_debug_o,
  output logic [TAG_W:0]    outstanding_inst_debug_o,
  output logic [TAG_W:0]    outstanding_data_debug_o
);

  localparam int NENT  = 1 << TAG_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_INST    = 2'd1;
  localparam logic [1:0] ST_INST_SQ = 2'd2;
  localparam logic [1:0] ST_DATA    = 2'd3;

  localparam logic [TAG_W:0] CNT_ONE = 1;

  logic [NENT-1:0][1:0] tbl_st;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 inst_prio;
  logic                 grant_inst, grant_data, resp_ok;
  logic                 alloc_en, ret_hit;
  logic [1:0]           alloc_state, ret_state;

  assign inst_prio = (starve_q == CNT_W'(STARVE_LIMIT));
  assign resp_ok   = rst_ni && (mem2proc_response_i != '0);

  // Outputs are gated by reset so the port goes quiet the moment reset asserts.
  assign grant_inst = rst_ni && icache_req_i && (inst_prio || !dcache_req_i);
  assign grant_data = rst_ni && dcache_req_i && !grant_inst;

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    if (grant_inst) begin
      proc2mem_command_o = BUS_LOAD;
      proc2mem_addr_o    = icache_addr_i;
    end else if (grant_data) begin
      proc2mem_command_o = dcache_cmd_i;
      proc2mem_addr_o    = dcache_addr_i;
      proc2mem_data_o    = (dcache_cmd_i == BUS_STORE) ? dcache_wdata_i : 64'd0;
    end
  end

  assign icache_accept_o = grant_inst && resp_ok;
  assign dcache_accept_o = grant_data && resp_ok;
  assign icache_tag_o    = icache_accept_o ? mem2proc_response_i : '0;
  assign dcache_tag_o    = dcache_accept_o ? mem2proc_response_i : '0;

  // Returns are routed from the registered state; the same-cycle update happens afterwards.
  assign ret_state = tbl_st[mem2proc_tag_i];
  assign ret_hit   = rst_ni && (mem2proc_tag_i != '0);

  assign icache_data_valid_o = ret_hit && (ret_state == ST_INST);
  assign dcache_data_valid_o = ret_hit && (ret_state == ST_DATA);
  assign icache_data_o       = icache_data_valid_o ? mem2proc_data_i : 64'd0;
  assign dcache_data_o       = dcache_data_valid_o ? mem2proc_data_i : 64'd0;
  assign icache_resp_tag_o   = icache_data_valid_o ? mem2proc_tag_i : '0;
  assign dcache_resp_tag_o   = dcache_data_valid_o ? mem2proc_tag_i : '0;

  assign alloc_en    = icache_accept_o || (dcache_accept_o && (dcache_cmd_i == BUS_LOAD));
  assign alloc_state = icache_accept_o ? (fetch_flush_i ? ST_INST_SQ : ST_INST) : ST_DATA;

  for (genvar gi = 0; gi < NENT; gi++) begin : g_ent
    logic [1:0] st_q, st_d;

    always_comb begin
      st_d = st_q;
      if (fetch_flush_i && (st_q == ST_INST)) st_d = ST_INST_SQ;
      if (ret_hit && (mem2proc_tag_i == TAG_W'(gi))) st_d = ST_FREE;
      if (alloc_en && (mem2proc_response_i == TAG_W'(gi))) st_d = alloc_state;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) st_q <= ST_FREE;
      else         st_q <= st_d;
    end

    assign tbl_st[gi] = st_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (!icache_req_i || icache_accept_o)
      starve_d = '0;
    else if (dcache_accept_o && !inst_prio)
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign inst_priority_debug_o = inst_prio;

  // Squashed fetch entries still count as live fetch tags until memory returns them.
  always_comb begin
    outstanding_inst_debug_o = '0;
    outstanding_data_debug_o = '0;
    for (int i = 0; i < NENT; i++) begin
      if (tbl_st[i] == ST_INST || tbl_st[i] == ST_INST_SQ)
        outstanding_inst_debug_o = outstanding_inst_debug_o + CNT_ONE;
      if (tbl_st[i] == ST_DATA)
        outstanding_data_debug_o = outstanding_data_debug_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_fetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_accept;
  logic [3:0]  icache_tag;
  logic        icache_data_valid;
  logic [63:0] icache_data;
  logic [3:0]  icache_resp_tag;
  logic        fetch_flush;
  logic        dcache_req;
  logic [1:0]  dcache_cmd;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic        dcache_accept;
  logic [3:0]  dcache_tag;
  logic        dcache_data_valid;
  logic [63:0] dcache_data;
  logic [3:0]  dcache_resp_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        inst_priority_debug;
  logic [4:0]  outstanding_inst_debug;
  logic [4:0]  outstanding_data_debug;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_mem_arbiter #(.XLEN(32), .TAG_W(4), .STARVE_LIMIT(4)) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .icache_req_i             (icache_req),
    .icache_addr_i            (icache_addr),
    .icache_accept_o          (icache_accept),
    .icache_tag_o             (icache_tag),
    .icache_data_valid_o      (icache_data_valid),
    .icache_data_o            (icache_data),
    .icache_resp_tag_o        (icache_resp_tag),
    .fetch_flush_i            (fetch_flush),
    .dcache_req_i             (dcache_req),
    .dcache_cmd_i             (dcache_cmd),
    .dcache_addr_i            (dcache_addr),
    .dcache_wdata_i           (dcache_wdata),
    .dcache_accept_o          (dcache_accept),
    .dcache_tag_o             (dcache_tag),
    .dcache_data_valid_o      (dcache_data_valid),
    .dcache_data_o            (dcache_data),
    .dcache_resp_tag_o        (dcache_resp_tag),
    .proc2mem_command_o       (proc2mem_command),
    .proc2mem_addr_o          (proc2mem_addr),
    .proc2mem_data_o          (proc2mem_data),
    .mem2proc_response_i      (mem2proc_response),
    .mem2proc_data_i          (mem2proc_data),
    .mem2proc_tag_i           (mem2proc_tag),
    .inst_priority_debug_o    (inst_priority_debug),
    .outstanding_inst_debug_o (outstanding_inst_debug),
    .outstanding_data_debug_o (outstanding_data_debug)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    icache_req = 0; icache_addr = '0; fetch_flush = 0;
    dcache_req = 0; dcache_cmd = 2'd0; dcache_addr = '0; dcache_wdata = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    // Reset: even a live request must not be accepted.
    icache_req = 1; icache_addr = 32'h80; mem2proc_response = 4'd3;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_icache_accept", icache_accept, 0);
    chk("rst_icache_tag", icache_tag, 0);
    chk("rst_cmd", proc2mem_command, 0);
    chk("rst_prio", inst_priority_debug, 0);
    chk("rst_out_inst", outstanding_inst_debug, 0);
    chk("rst_out_data", outstanding_data_debug, 0);
    next_cycle(); rst_n = 1;

    // Fetch only
    next_cycle(); icache_req = 1; icache_addr = 32'h100; mem2proc_response = 4'd3; settle();
    $display("[TB] fetch addr 0x100 resp 3");
    chk("f_accept", icache_accept, 1);
    chk("f_tag", icache_tag, 3);
    chk("f_cmd", proc2mem_command, 1);
    chk("f_addr", proc2mem_addr, 32'h100);
    chk("f_pdata", proc2mem_data, 0);
    chk("f_daccept", dcache_accept, 0);
    next_cycle(); settle();
    chk("f_out_inst", outstanding_inst_debug, 1);
    next_cycle(); mem2proc_tag = 4'd3; mem2proc_data = 64'hAAAA; settle();
    $display("[TB] return tag 3 data 0xAAAA");
    chk("f_rvalid", icache_data_valid, 1);
    chk("f_rdata", icache_data, 64'hAAAA);
    chk("f_rtag", icache_resp_tag, 3);
    chk("f_rdvalid", dcache_data_valid, 0);
    next_cycle(); settle();
    chk("f_out_inst_free", outstanding_inst_debug, 0);

    // Conflict: data wins by default; loads drive zero store data
    next_cycle();
    icache_req = 1; icache_addr = 32'h200;
    dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'h300; dcache_wdata = 64'hDEAD;
    mem2proc_response = 4'd5; settle();
    $display("[TB] conflict resp 5");
    chk("c_daccept", dcache_accept, 1);
    chk("c_dtag", dcache_tag, 5);
    chk("c_iaccept", icache_accept, 0);
    chk("c_itag", icache_tag, 0);
    chk("c_cmd", proc2mem_command, 1);
    chk("c_addr", proc2mem_addr, 32'h300);
    chk("c_pdata", proc2mem_data, 0);
    next_cycle(); icache_req = 1; icache_addr = 32'h200; mem2proc_response = 4'd6; settle();
    chk("c_iaccept2", icache_accept, 1);
    chk("c_itag2", icache_tag, 6);
    next_cycle(); settle();
    chk("c_out_inst", outstanding_inst_debug, 1);
    chk("c_out_data", outstanding_data_debug, 1);
    next_cycle(); mem2proc_tag = 4'd5; mem2proc_data = 64'h5555; settle();
    $display("[TB] return tag 5");
    chk("c_dvalid", dcache_data_valid, 1);
    chk("c_ddata", dcache_data, 64'h5555);
    chk("c_drtag", dcache_resp_tag, 5);
    chk("c_ivalid_none", icache_data_valid, 0);
    next_cycle(); mem2proc_tag = 4'd6; mem2proc_data = 64'h6666; settle();
    chk("c_ivalid6", icache_data_valid, 1);
    chk("c_dvalid6_none", dcache_data_valid, 0);
    next_cycle(); settle();
    chk("c_out_data0", outstanding_data_debug, 0);

    // Starvation: four lost cycles, fetch wins on the fifth
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      icache_req = 1; icache_addr = 32'h400;
      dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'h500;
      mem2proc_response = 4'(k); settle();
      $display("[TB] starve cycle %0d resp %0d", k, k);
      chk("s_daccept", dcache_accept, 1);
      chk("s_prio_off", inst_priority_debug, 0);
    end
    next_cycle();
    icache_req = 1; icache_addr = 32'h400;
    dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'h500;
    mem2proc_response = 4'd8; settle();
    $display("[TB] starve cycle 5 resp 8");
    chk("s_prio_on", inst_priority_debug, 1);
    chk("s_iaccept", icache_accept, 1);
    chk("s_itag", icache_tag, 8);
    chk("s_daccept_lose", dcache_accept, 0);
    chk("s_addr", proc2mem_addr, 32'h400);
    next_cycle(); dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'h500; settle();
    chk("s_prio_clear", inst_priority_debug, 0);
    next_cycle(); settle();
    chk("s_out_data", outstanding_data_debug, 4);
    chk("s_out_inst", outstanding_inst_debug, 1);
    next_cycle(); mem2proc_tag = 4'd8; settle();
    chk("s_ivalid8", icache_data_valid, 1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle(); mem2proc_tag = 4'(k); mem2proc_data = 64'(k); settle();
      chk("s_dvalid_ret", dcache_data_valid, 1);
    end

    // Flush squashes outstanding fetch tags 2 and 7
    next_cycle(); icache_req = 1; icache_addr = 32'h700; mem2proc_response = 4'd2; settle();
    chk("fl_acc2", icache_accept, 1);
    next_cycle(); icache_req = 1; icache_addr = 32'h708; mem2proc_response = 4'd7; settle();
    chk("fl_acc7", icache_accept, 1);
    next_cycle(); fetch_flush = 1; settle();
    $display("[TB] flush with tags 2,7 outstanding");
    chk("fl_out2_pre", outstanding_inst_debug, 2);
    next_cycle(); settle();
    chk("fl_out2_post", outstanding_inst_debug, 2);
    next_cycle(); mem2proc_tag = 4'd2; mem2proc_data = 64'h2222; settle();
    chk("fl_sq2", icache_data_valid, 0);
    next_cycle(); settle();
    chk("fl_out1", outstanding_inst_debug, 1);
    next_cycle(); mem2proc_tag = 4'd7; settle();
    chk("fl_sq7", icache_data_valid, 0);
    next_cycle(); settle();
    chk("fl_out0", outstanding_inst_debug, 0);
    // Fetch accepted during the flush cycle is born squashed
    next_cycle(); icache_req = 1; icache_addr = 32'h800; fetch_flush = 1; mem2proc_response = 4'd10; settle();
    chk("fl_acc10", icache_accept, 1);
    next_cycle(); mem2proc_tag = 4'd10; settle();
    chk("fl_sq10", icache_data_valid, 0);

    // Store: data on the bus, no entry allocated, stray return ignored
    next_cycle();
    dcache_req = 1; dcache_cmd = 2'd2; dcache_addr = 32'h600; dcache_wdata = 64'h1234;
    mem2proc_response = 4'd9; settle();
    $display("[TB] store wdata 0x1234 resp 9");
    chk("st_cmd", proc2mem_command, 2);
    chk("st_pdata", proc2mem_data, 64'h1234);
    chk("st_accept", dcache_accept, 1);
    chk("st_tag", dcache_tag, 9);
    next_cycle(); settle();
    chk("st_out_data", outstanding_data_debug, 0);
    next_cycle(); mem2proc_tag = 4'd9; mem2proc_data = 64'h9999; settle();
    chk("st_stray_d", dcache_data_valid, 0);
    chk("st_stray_i", icache_data_valid, 0);

    // Async reset with three live entries
    next_cycle(); icache_req = 1; icache_addr = 32'h900; mem2proc_response = 4'd1; settle();
    next_cycle(); dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'hA00; mem2proc_response = 4'd2; settle();
    next_cycle(); dcache_req = 1; dcache_cmd = 2'd1; dcache_addr = 32'hA08; mem2proc_response = 4'd3; settle();
    next_cycle(); icache_req = 1; icache_addr = 32'h908; mem2proc_response = 4'd4; settle();
    chk("ar_live_inst", outstanding_inst_debug, 1);
    chk("ar_live_data", outstanding_data_debug, 2);
    chk("ar_pre_accept", icache_accept, 1);
    #2 rst_n = 0;
    settle();
    $display("[TB] async reset asserted mid-cycle");
    chk("ar_accept", icache_accept, 0);
    chk("ar_cmd", proc2mem_command, 0);
    chk("ar_out_inst", outstanding_inst_debug, 0);
    chk("ar_out_data", outstanding_data_debug, 0);
    next_cycle(); rst_n = 1;
    next_cycle(); mem2proc_tag = 4'd1; settle();
    chk("ar_drop1", icache_data_valid, 0);
    next_cycle(); mem2proc_tag = 4'd2; settle();
    chk("ar_drop2", dcache_data_valid, 0);

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
